// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the CHIP-8 data RAM port between the CPU data path (r0)
// and the sprite engine (r1). One requester owns the port per burst and the
// arbiter issues one byte access per cycle. A burst steps IDLE -> BURST ->
// DRAIN -> DONE -> IDLE.
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   : ties in IDLE go to the requester not granted most recently
//   undefined : fixed priority, r0 wins ties

module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [LEN_W-1:0]  r0_len,
    input  logic [7:0]        r0_wdata,
    output logic              r0_gnt,
    output logic              r0_wready,
    output logic [7:0]        r0_rdata,
    output logic              r0_rvalid,
    output logic              r0_done,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [LEN_W-1:0]  r1_len,
    input  logic [7:0]        r1_wdata,
    output logic              r1_gnt,
    output logic              r1_wready,
    output logic [7:0]        r1_rdata,
    output logic              r1_rvalid,
    output logic              r1_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner;    // 0 = r0, 1 = r1
    logic                r_we;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic                r_rd_pend;  // a read address went out last cycle

    logic                w_any;
    logic                w_sel;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [LEN_W-1:0]    w_sel_len;
    logic                w_burst;
    logic                w_gnt;
    logic                w_done;

    assign w_any = r0_req | r1_req;

`ifdef ROUND_ROBIN_EN
    logic r_last;  // requester granted most recently

    // Arbitration: a tie goes to whoever did not win last time
    always_comb begin
        w_sel = 1'b0;
        if (r0_req && r1_req) w_sel = ~r_last;
        else if (r1_req)      w_sel = 1'b1;
    end

    // Pointer follows every grant; reset makes r0 win the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_last <= 1'b1;
        else if (r_state == S_IDLE && w_any) r_last <= w_sel;
    end
`else
    // Arbitration: fixed priority, r0 wins every tie
    always_comb begin
        w_sel = ~r0_req;
    end
`endif

    // Mux the winning requester's burst descriptor
    always_comb begin
        w_sel_we   = w_sel ? r1_we   : r0_we;
        w_sel_addr = w_sel ? r1_addr : r0_addr;
        w_sel_len  = w_sel ? r1_len  : r0_len;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic and state-decoded strobes
    always_comb begin
        w_next  = r_state;
        w_burst = 1'b0;
        w_gnt   = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_gnt = 1'b0;
                if (w_any) w_next = (w_sel_len != '0) ? S_BURST : S_DONE;
            end
            S_BURST: begin
                w_burst = 1'b1;
                if (r_idx == r_len - LEN_W'(1)) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Burst descriptor capture at grant, byte index, read-return tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_base    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_burst & ~r_we;
            if (r_state == S_IDLE && w_any) begin
                r_owner <= w_sel;
                r_we    <= w_sel_we;
                r_base  <= w_sel_addr;
                r_len   <= w_sel_len;
                r_idx   <= '0;
            end else if (w_burst) begin
                r_idx   <= r_idx + LEN_W'(1);
            end
        end
    end

    // RAM port: driven only during BURST, address wraps at the top of RAM
    assign mem_we    = w_burst & r_we;
    assign mem_addr  = w_burst ? (r_base + ADDR_W'(r_idx)) : '0;
    assign mem_wdata = mem_we ? (r_owner ? r1_wdata : r0_wdata) : 8'h00;

    // Requester-side strobes, gated to the owner
    assign r0_gnt    = w_gnt & ~r_owner;
    assign r1_gnt    = w_gnt &  r_owner;
    assign r0_wready = mem_we & ~r_owner;
    assign r1_wready = mem_we &  r_owner;
    assign r0_rvalid = r_rd_pend & ~r_owner;
    assign r1_rvalid = r_rd_pend &  r_owner;
    assign r0_rdata  = r0_rvalid ? mem_rdata : 8'h00;
    assign r1_rdata  = r1_rvalid ? mem_rdata : 8'h00;
    assign r0_done   = w_done & ~r_owner;
    assign r1_done   = w_done &  r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected (cycle, value)
// events per output stream; a monitor pops and compares each observed event.
`timescale 1ns/1ps

module tb_mem_arbiter;

    typedef logic [7:0] bytes_t [16];
    typedef struct { int cyc; int val; } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  we  = '0;
    logic [11:0] addr [2];
    logic [3:0]  len  [2];
    logic [7:0]  wbuf [2][16];
    logic [3:0]  wptr [2];

    logic        r0_gnt, r0_wready, r0_rvalid, r0_done;
    logic        r1_gnt, r1_wready, r1_rvalid, r1_done;
    logic [7:0]  r0_rdata, r1_rdata;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  ram [4096];

    // streams: 0 gnt0 edge, 1 gnt1 edge, 2 write beat, 3 rvalid0, 4 rvalid1, 5 done0, 6 done1
    item_t q [7][$];
    string nm [7] = '{"gnt0", "gnt1", "wbeat", "rvalid0", "rvalid1", "done0", "done1"};
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    logic  pg0 = 1'b0, pg1 = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_len(len[0]),
        .r0_wdata(wbuf[0][wptr[0]]), .r0_gnt(r0_gnt), .r0_wready(r0_wready),
        .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid), .r0_done(r0_done),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_len(len[1]),
        .r1_wdata(wbuf[1][wptr[1]]), .r1_gnt(r1_gnt), .r1_wready(r1_wready),
        .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid), .r1_done(r1_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // RAM model with registered read
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Requester write-data pointers advance on wready, rewind on done/reset
    always @(posedge clk) begin
        if (rst) begin
            wptr[0] <= '0;
            wptr[1] <= '0;
        end else begin
            if (r0_done) wptr[0] <= '0; else if (r0_wready) wptr[0] <= wptr[0] + 4'd1;
            if (r1_done) wptr[1] <= '0; else if (r1_wready) wptr[1] <= wptr[1] + 4'd1;
        end
    end

    // Monitor: cycle counter, then sample 1ns after the edge
    always @(posedge clk) begin
        bit pres [7];
        int v [7];
        item_t e;
        cyc++;
        #1;
        pres[0] = (r0_gnt != pg0);               v[0] = int'(r0_gnt);
        pres[1] = (r1_gnt != pg1);               v[1] = int'(r1_gnt);
        pres[2] = mem_we | r0_wready | r1_wready;
        v[2]    = int'({mem_we, r1_wready, r0_wready, mem_addr, mem_wdata});
        pres[3] = r0_rvalid;                     v[3] = int'(r0_rdata);
        pres[4] = r1_rvalid;                     v[4] = int'(r1_rdata);
        pres[5] = r0_done;                       v[5] = 0;
        pres[6] = r1_done;                       v[6] = 0;
        pg0 = r0_gnt;
        pg1 = r1_gnt;
        for (int k = 0; k < 7; k++) begin
            if (pres[k]) begin
                checks++;
                if (q[k].size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected event at cycle %0d got=%0h", nm[k], cyc, v[k]);
                end else begin
                    e = q[k].pop_front();
                    if (e.cyc != cyc || e.val != v[k]) begin
                        errors++;
                        $display("FAIL %s got cycle %0d val %0h, want cycle %0d val %0h",
                                 nm[k], cyc, v[k], e.cyc, e.val);
                    end
                end
            end
        end
    end

    function automatic void put(int k, int c, int v);
        q[k].push_back('{cyc: c, val: v});
    endfunction

    // Expected events for one full burst whose IDLE/sample cycle is c0
    function automatic void push(int r, bit w, int a, int l, int c0, bytes_t d);
        put(r, c0 + 1, 1);
        if (l == 0) begin
            put(5 + r, c0 + 1, 0);
            put(r, c0 + 2, 0);
        end else begin
            for (int i = 0; i < l; i++) begin
                if (w) put(2, c0 + 1 + i, (1 << 22) | ((r == 1) ? (1 << 21) : (1 << 20)) |
                                          (((a + i) & 12'hFFF) << 8) | int'(d[i]));
                else   put(3 + r, c0 + 2 + i, int'(d[i]));
            end
            put(5 + r, c0 + l + 2, 0);
            put(r, c0 + l + 3, 0);
        end
    endfunction

    // Issue one burst from a negedge, wait (bounded) for done, drop req
    task automatic drive(int r, bit w, int a, int l);
        bit seen = 0;
        we[r] = w; addr[r] = 12'(a); len[r] = 4'(l); req[r] = 1'b1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            seen = (r == 0) ? r0_done : r1_done;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL timeout waiting done%0d got=0 want=1", r);
        end
        req[r] = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chk_zero(string name);
        chk(name, int'({r0_gnt, r0_wready, r0_rdata, r0_rvalid, r0_done,
                        r1_gnt, r1_wready, r1_rdata, r1_rvalid, r1_done,
                        mem_we, mem_addr, mem_wdata}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bytes_t d;
        int c;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h200] = 8'h6A; ram[12'h201] = 8'h02; ram[12'h202] = 8'h6B;
        for (int i = 0; i < 10; i++) ram[12'h400 + i] = 8'hEE;
        for (int r = 0; r < 2; r++) begin
            addr[r] = '0; len[r] = '0;
            for (int i = 0; i < 16; i++) wbuf[r][i] = 8'h00;
        end
        d = '{default: 8'h00};

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("idle_outputs");

        // r0 read 0x200 len 3
        d[0] = 8'h6A; d[1] = 8'h02; d[2] = 8'h6B;
        push(0, 0, 12'h200, 3, cyc, d);
        drive(0, 0, 12'h200, 3);

        // r1 write 0xFFE len 4, wraps to 0x000
        wbuf[1][0] = 8'h11; wbuf[1][1] = 8'h22; wbuf[1][2] = 8'h33; wbuf[1][3] = 8'h44;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        push(1, 1, 12'hFFE, 4, cyc, d);
        drive(1, 1, 12'hFFE, 4);

        // read the wrapped bytes back through r1
        push(1, 0, 12'hFFE, 4, cyc, d);
        drive(1, 0, 12'hFFE, 4);

        // zero-length burst on r0
        push(0, 0, 12'h123, 0, cyc, d);
        drive(0, 0, 12'h123, 0);

        // r1 arrives mid r0 burst; r1 served in first IDLE after r0 done
        c = cyc;
        d[0] = 8'h6A; d[1] = 8'h02; d[2] = 8'h6B;
        push(0, 0, 12'h200, 3, c, d);
        d[0] = 8'h6B;
        push(1, 0, 12'h202, 1, c + 6, d);
        fork
            drive(0, 0, 12'h200, 3);
            begin
                repeat (2) @(negedge clk);
                drive(1, 0, 12'h202, 1);
            end
        join
        repeat (2) @(negedge clk);

        // reset pulse so the tie pointer starts from its reset value
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("reset_pulse_outputs");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // both requesting continuously, len 2 writes
        wbuf[0][0] = 8'hA0; wbuf[0][1] = 8'hA1;
        wbuf[1][0] = 8'hB0; wbuf[1][1] = 8'hB1;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
            int o = k % 2;
`else
            int o = 0;
`endif
            d[0] = (o == 0) ? 8'hA0 : 8'hB0;
            d[1] = (o == 0) ? 8'hA1 : 8'hB1;
            push(o, 1, (o == 0) ? 12'h300 : 12'h310, 2, c + 5 * k, d);
        end
        we = 2'b11; addr[0] = 12'h300; addr[1] = 12'h310; len[0] = 4'd2; len[1] = 4'd2;
        req = 2'b11;
        while (cyc != c + 19) @(negedge clk);
        req = 2'b00;
        repeat (2) @(negedge clk);

        // reset during a 10-byte write after 4 bytes have landed
        for (int i = 0; i < 10; i++) wbuf[0][i] = 8'(i + 1);
        c = cyc;
        put(0, c + 1, 1);
        for (int i = 0; i < 5; i++)
            put(2, c + 1 + i, (1 << 22) | (1 << 20) | ((12'h400 + i) << 8) | (i + 1));
        put(0, c + 6, 0);
        we[0] = 1'b1; addr[0] = 12'h400; len[0] = 4'd10; req[0] = 1'b1;
        do begin
            @(posedge clk);
            #2;
        end while (cyc != c + 5);
        rst = 1'b1;
        #1;
        chk_zero("reset_midburst_outputs");
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++)
            chk($sformatf("ram_400_%0d", i), int'(ram[12'h400 + i]), (i < 4) ? i + 1 : 8'hEE);

        // every expected event must have been seen
        for (int k = 0; k < 7; k++)
            chk({nm[k], "_leftover"}, q[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
